// File: rtl/cmp_hit_accumulator_pkg.sv
// Shared types, default parameters and helper function for cmp_hit_accumulator.
// Optional feature macro: CMP_HIT_CONTINUOUS_EN (back-to-back windows).
package cmp_hit_pkg;

  localparam int DEF_N_CH        = 3;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_WIN_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Increment that sticks at max_val instead of wrapping. Counters up to
  // 32 bits wide are passed zero-extended; the caller truncates the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/cmp_hit_accumulator_if.sv
// Result bus of cmp_hit_accumulator: packed counts and saturation flags
// delivered with a valid/ready handshake.
interface cmp_hit_accumulator_if
  import cmp_hit_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
);
  logic                    res_valid;
  logic                    res_ready;
  logic [N_CH*CNT_W-1:0]   res_data;
  logic [N_CH-1:0]         res_sat;

  modport master (output res_valid, output res_data, output res_sat, input res_ready);
  modport slave  (input res_valid, input res_data, input res_sat, output res_ready);
endinterface

// File: rtl/cmp_hit_accumulator_sync.sv
// Single-bit flop chain bringing one comparator output into free_run_clk.
module cmp_hit_sync
  import cmp_hit_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic free_run_clk,
  input  logic free_run_rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw bit through the chain; the last stage is the usable sample.
  always_ff @(posedge free_run_clk) begin
    if (!free_run_rst_n) chain <= '0;
    else                 chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cmp_hit_accumulator.sv
// N-channel comparator hit accumulator: counts '1' samples per channel over a
// programmable window and hands the packed counts over a valid/ready bus.
// Optional feature macro: CMP_HIT_CONTINUOUS_EN -- when defined, a completed
// handshake immediately re-arms a new window with the same length.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | one alignment cycle, counters already cleared
// ACCUM | counting synchronised hits, len_r cycles
// HOLD  | result presented until res_ready
module cmp_hit_accumulator
  import cmp_hit_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              free_run_clk,
  input  logic              free_run_rst_n,
  input  logic [N_CH-1:0]   cmp_in,
  input  logic [WIN_W-1:0]  window_len,
  input  logic              start,
  output logic              busy,
  output logic              triger,
  cmp_hit_accumulator_if.master res_if
);

  localparam logic [CNT_W-1:0] CNT_ALL1 = '1;

  state_t                       state_q, state_d;
  logic [N_CH-1:0]              cmp_s;
  logic [WIN_W-1:0]             len_r;
  logic [WIN_W-1:0]             sample_cnt;
  logic [N_CH-1:0][CNT_W-1:0]   cnt_q;
  logic [N_CH-1:0]              sat_q;
  logic                         last_sample;
  logic                         handshake;
  logic                         start_win;
  logic                         rearm;
  logic                         res_valid_int;

  for (genvar k = 0; k < N_CH; k++) begin : g_sync
    cmp_hit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .free_run_clk   (free_run_clk),
      .free_run_rst_n (free_run_rst_n),
      .d              (cmp_in[k]),
      .q              (cmp_s[k])
    );
  end

  assign last_sample = (sample_cnt == (len_r - WIN_W'(1)));
  assign handshake   = (state_q == HOLD) && res_if.res_ready;
  assign start_win   = (state_q == IDLE) && start;
`ifdef CMP_HIT_CONTINUOUS_EN
  assign rearm       = handshake;
`else
  assign rearm       = 1'b0;
`endif

  // State register.
  always_ff @(posedge free_run_clk) begin
    if (!free_run_rst_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ARM;
      ARM:     state_d = ACCUM;
      ACCUM:   if (last_sample) state_d = HOLD;
      HOLD: begin
        if (res_if.res_ready) begin
`ifdef CMP_HIT_CONTINUOUS_EN
          state_d = ARM;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy          = (state_q != IDLE);
    triger        = (state_q == ACCUM) && (sample_cnt == '0);
    res_valid_int = (state_q == HOLD);
  end

  // Window length latch, sample counter and per-channel saturating counters.
  // Counters are cleared when a window is armed so HOLD keeps them stable.
  always_ff @(posedge free_run_clk) begin
    if (!free_run_rst_n) begin
      len_r      <= '0;
      sample_cnt <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
    end else begin
      if (start_win)
        len_r <= (window_len == '0) ? WIN_W'(1) : window_len;
      if (start_win || rearm) begin
        sample_cnt <= '0;
        cnt_q      <= '0;
        sat_q      <= '0;
      end else if (state_q == ACCUM) begin
        sample_cnt <= sample_cnt + WIN_W'(1);
        for (int k = 0; k < N_CH; k++) begin
          if (cmp_s[k]) begin
            cnt_q[k] <= CNT_W'(sat_inc(32'(cnt_q[k]), 32'(CNT_ALL1)));
            if (cnt_q[k] == CNT_ALL1) sat_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign res_if.res_valid = res_valid_int;
  assign res_if.res_data  = cnt_q;
  assign res_if.res_sat   = sat_q;

endmodule

// File: tb/tb_cmp_hit_accumulator.sv
// Directed self-checking bench for cmp_hit_accumulator (default and
// CMP_HIT_CONTINUOUS_EN builds).
module tb_cmp_hit_accumulator;

  logic        free_run_clk = 1'b0;
  logic        free_run_rst_n;
  logic [2:0]  cmp_in, cmp_in_s;
  logic [15:0] window_len, window_len_s;
  logic        start, start_s;
  logic        busy, triger, busy_s, triger_s;

  int n_checks = 0;
  int n_errors = 0;

  cmp_hit_accumulator_if #(.N_CH(3), .CNT_W(16)) bus0 ();
  cmp_hit_accumulator_if #(.N_CH(3), .CNT_W(4))  bus_s ();

  always #5 free_run_clk = ~free_run_clk;

  cmp_hit_accumulator #(.N_CH(3), .CNT_W(16), .WIN_W(16), .SYNC_STAGES(2)) u_dut (
    .free_run_clk   (free_run_clk),
    .free_run_rst_n (free_run_rst_n),
    .cmp_in         (cmp_in),
    .window_len     (window_len),
    .start          (start),
    .busy           (busy),
    .triger         (triger),
    .res_if         (bus0)
  );

  cmp_hit_accumulator #(.N_CH(3), .CNT_W(4), .WIN_W(16), .SYNC_STAGES(2)) u_dut_sat (
    .free_run_clk   (free_run_clk),
    .free_run_rst_n (free_run_rst_n),
    .cmp_in         (cmp_in_s),
    .window_len     (window_len_s),
    .start          (start_s),
    .busy           (busy_s),
    .triger         (triger_s),
    .res_if         (bus_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge free_run_clk);
    @(negedge free_run_clk);
  endtask

  // Presents start in the current cycle (t) and returns, relative to t, the
  // cycle where triger first rose and where res_valid rose (-1 if never).
  task automatic run_window(input logic [15:0] wl, output int trig_cyc, output int valid_cyc);
    window_len = wl;
    start      = 1'b1;
    trig_cyc   = -1;
    valid_cyc  = -1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      start = 1'b0;
      if (triger && trig_cyc < 0) trig_cyc = c;
      if (bus0.res_valid) begin
        valid_cyc = c;
        break;
      end
    end
  endtask

  task automatic handshake();
    bus0.res_ready = 1'b1;
    tick();
    bus0.res_ready = 1'b0;
  endtask

  initial begin
    int tc, vc, lat, prev, cur, trig_last, trig_n;
    bit ok;
    logic [47:0] held;

    free_run_rst_n   = 1'b0;
    cmp_in           = '0;
    cmp_in_s         = '0;
    window_len       = '0;
    window_len_s     = '0;
    start            = 1'b0;
    start_s          = 1'b0;
    bus0.res_ready   = 1'b0;
    bus_s.res_ready  = 1'b0;
    repeat (3) tick();

    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_trig",  64'(triger), 64'd0);
    chk("rst_valid", 64'(bus0.res_valid), 64'd0);
    chk("rst_data",  64'(bus0.res_data), 64'd0);
    chk("rst_sat",   64'(bus0.res_sat), 64'd0);

    free_run_rst_n = 1'b1;
    tick();

`ifdef CMP_HIT_CONTINUOUS_EN
    // Back-to-back windows of 5 with a toggling input: 7-cycle period and
    // counts alternating 3/2 (or 2/3) because the period is odd.
    cmp_in         = 3'b000;
    bus0.res_ready = 1'b1;
    window_len     = 16'd5;
    start          = 1'b1;
    trig_last      = -1;
    trig_n         = 0;
    prev           = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start = 1'b0;
      if (triger) begin
        if (trig_last >= 0) chk("cont_trig_period", 64'(c - trig_last), 64'd7);
        trig_last = c;
        trig_n++;
      end
      if (bus0.res_valid) begin
        cur = int'(bus0.res_data[15:0]);
        chk("cont_cnt_range", 64'((cur == 2) || (cur == 3)), 64'd1);
        chk("cont_chan_equal", 64'(bus0.res_data), 64'({cur[15:0], cur[15:0], cur[15:0]}));
        if (prev >= 0) chk("cont_contig", 64'(prev + cur), 64'd5);
        prev = cur;
      end
      cmp_in = ~cmp_in;
    end
    chk("cont_trig_count", 64'(trig_n >= 8), 64'd1);
    chk("cont_busy", 64'(busy), 64'd1);
`else
    // Window of 10 with channels 0 and 2 high.
    cmp_in = 3'b101;
    repeat (3) tick();
    run_window(16'd10, tc, vc);
    chk("w10_trig_cyc",  64'(tc), 64'd2);
    chk("w10_valid_cyc", 64'(vc), 64'd12);
    chk("w10_data", 64'(bus0.res_data), 64'({16'd10, 16'd0, 16'd10}));
    chk("w10_sat",  64'(bus0.res_sat), 64'd0);
    handshake();
    chk("w10_idle_busy",  64'(busy), 64'd0);
    chk("w10_idle_valid", 64'(bus0.res_valid), 64'd0);

    // window_len=0 behaves as a single-sample window.
    cmp_in = 3'b111;
    repeat (3) tick();
    run_window(16'd0, tc, vc);
    chk("w0_trig_cyc",  64'(tc), 64'd2);
    chk("w0_valid_cyc", 64'(vc), 64'd3);
    chk("w0_data", 64'(bus0.res_data), 64'({16'd1, 16'd1, 16'd1}));
    handshake();

    // Backpressure with start pulsed during HOLD, then start and res_ready
    // together: transfer only, no second window.
    cmp_in = 3'b011;
    repeat (3) tick();
    run_window(16'd4, tc, vc);
    chk("bp_valid_cyc", 64'(vc), 64'd6);
    chk("bp_data", 64'(bus0.res_data), 64'({16'd0, 16'd4, 16'd4}));
    held = {16'd0, 16'd4, 16'd4};
    cmp_in = 3'b111;
    for (int i = 0; i < 7; i++) begin
      start = (i == 3);
      tick();
      chk("bp_hold_valid", 64'(bus0.res_valid), 64'd1);
      chk("bp_hold_data",  64'(bus0.res_data), 64'(held));
    end
    start = 1'b1;
    bus0.res_ready = 1'b1;
    tick();
    start = 1'b0;
    bus0.res_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (busy || bus0.res_valid) ok = 1'b0;
      tick();
    end
    chk("bp_no_second_window", 64'(ok), 64'd1);

    // Reset for one cycle at sample 4 of a 10-sample window.
    window_len = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_busy_before_rst", 64'(busy), 64'd1);
    free_run_rst_n = 1'b0;
    tick();
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(bus0.res_valid), 64'd0);
    chk("mid_rst_data",  64'(bus0.res_data), 64'd0);
    chk("mid_rst_trig",  64'(triger), 64'd0);
    free_run_rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || bus0.res_valid) ok = 1'b0;
    end
    chk("mid_rst_no_result", 64'(ok), 64'd1);
    run_window(16'd2, tc, vc);
    chk("post_rst_valid_cyc", 64'(vc), 64'd4);
    chk("post_rst_data", 64'(bus0.res_data), 64'({16'd2, 16'd2, 16'd2}));
    handshake();

    // Saturation with 4-bit counters: 20 hits saturate, 15 hits do not.
    cmp_in_s = 3'b001;
    repeat (3) tick();
    window_len_s = 16'd20;
    start_s = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      start_s = 1'b0;
      if (bus_s.res_valid) begin
        lat = c;
        break;
      end
    end
    chk("sat20_valid_cyc", 64'(lat), 64'd22);
    chk("sat20_data", 64'(bus_s.res_data), 64'h00F);
    chk("sat20_sat",  64'(bus_s.res_sat), 64'b001);
    bus_s.res_ready = 1'b1;
    tick();
    bus_s.res_ready = 1'b0;

    window_len_s = 16'd15;
    start_s = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      start_s = 1'b0;
      if (bus_s.res_valid) begin
        lat = c;
        break;
      end
    end
    chk("sat15_valid_cyc", 64'(lat), 64'd17);
    chk("sat15_data", 64'(bus_s.res_data), 64'h00F);
    chk("sat15_sat",  64'(bus_s.res_sat), 64'b000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmp_hit_accumulator.md
Name: cmp_hit_accumulator

Overview:
- N-channel successor to the fixed three-comparator (S11/S21/ref) sampling path.
- Synchronises N_CH comparator bits and counts per-channel '1' samples over a programmable window.
- Presents the packed counts through a valid/ready handshake and emits a scope trigger pulse at window start.
- Sits between the comparator IBUFDS outputs and the MCU/GTH data path, in the free_run_clk domain.

Parameters:
- N_CH, 3, number of comparator channels (1..16).
- CNT_W, 16, width of each per-channel hit counter.
- WIN_W, 16, width of the window-length input.
- SYNC_STAGES, 2, synchroniser flops per comparator input (>=2).

Ports:
- free_run_clk  in  1  sole clock.
- free_run_rst_n  in  1  synchronous, active-low reset.
- cmp_in  in  N_CH  raw comparator outputs, asynchronous to free_run_clk.
- window_len  in  WIN_W  samples per window; sampled on accepted start.
- start  in  1  request to begin a window.
- res_ready  in  1  consumer ready for results.
- res_valid  out  1  result available.
- res_data  out  N_CH*CNT_W  channel k count at bits [k*CNT_W +: CNT_W].
- res_sat  out  N_CH  per-channel saturation flag, valid with res_valid.
- busy  out  1  high in any state except IDLE.
- triger  out  1  one-cycle pulse on the first ACCUM cycle.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the counters and synchroniser flops clear.
- Synchroniser: each cmp_in bit passes through SYNC_STAGES flops; sampled value cmp_s = last stage.
- FSM states: IDLE, ARM, ACCUM, HOLD.
- IDLE -> ARM when start=1:
  - latch len_r = (window_len==0) ? 1 : window_len;
  - clear counters and sat flags.
- ARM -> ACCUM unconditionally, one cycle later. ARM aligns the first counted sample after the start edge.
- ACCUM:
  - Each cycle, for every channel with cmp_s[k]=1, counter[k] increments.
  - A counter at all-ones holds and sets sat[k]; there is no wrap-around.
  - Sample counter runs 0..len_r-1. After exactly len_r counted cycles -> HOLD.
  - triger=1 only in the first ACCUM cycle.
- HOLD:
  - res_valid=1; res_data/res_sat hold stable while res_valid && !res_ready.
  - Transfer occurs when res_valid && res_ready. Next state is IDLE (or ARM, see Optional Feature).
- Latency: start accepted at cycle t; first sample counted at t+2; res_valid asserted at t+2+len_r.
- start outside IDLE is ignored and not queued.
- res_ready is a don't-care outside HOLD.
- Reset asserted mid-window: counters and FSM clear on the next edge; any partial result is discarded and res_valid is never asserted for it.
- Simultaneous events: start and res_ready in the same HOLD cycle complete the transfer only; that start is ignored.
- Counter arithmetic is unsigned CNT_W bits. The sample counter is WIN_W bits, so window_len = 2^WIN_W-1 is the maximum window.

Optional Feature:
- Macro: CMP_HIT_CONTINUOUS_EN.
- Defined:
  - On handshake in HOLD, the FSM goes directly to ARM, reusing len_r and clearing counters, so windows repeat back-to-back.
  - triger pulses at each window start.
  - start=0 sampled in the handshake cycle still re-arms; only reset stops the loop.
  - With res_ready held at 1, the window period is len_r+2 cycles (ARM + len_r ACCUM + HOLD).
- Undefined: single-shot; HOLD -> IDLE on handshake.

Decomposition:
- Package cmp_hit_pkg holds:
  - state enum {IDLE, ARM, ACCUM, HOLD};
  - default parameter constants;
  - a saturating-increment function.
- One sub-module: cmp_hit_sync, a per-bit SYNC_STAGES flop chain, instantiated N_CH wide.
- Counters and FSM stay in the top.

Test Plan:
- Pulse start=1 with window_len=10 and cmp_in=3'b101 held steady:
  - expect triger at t+2 and res_valid at t+12;
  - expect res_data = {16'd10,16'd0,16'd10} and res_sat=0.
- Run window_len=0 with cmp_in=3'b111 -> all counts=1 and res_valid at t+3.
- Force saturation: CNT_W=4, window_len=20, cmp_in[0]=1 -> count[0]=15 and res_sat[0]=1, other flags 0.
- Backpressure: hold res_ready=0 for 7 cycles in HOLD with start pulsed meanwhile:
  - res_data stays stable and res_valid stays 1;
  - after the handshake the FSM returns to IDLE with no second window.
- Drop free_run_rst_n for 1 cycle mid-ACCUM at sample 4 of 10:
  - outputs go to 0 and the FSM returns to IDLE;
  - no res_valid appears until a new start.
- With CMP_HIT_CONTINUOUS_EN, window_len=5, res_ready=1 and cmp_in toggling every cycle:
  - triger fires every 7 cycles;
  - each count is 2 or 3, and successive windows are contiguous.
